gauss_pix_pack_8px: RTL and testbench
=====================================

GAUSS_PIX_PACK_8PX -- requirements
Module: pix_pack_8px

Interface
REQ-001 SHALL have parameter W, default 3124, line width in pixels (W >= 8).
REQ-002 SHALL have parameter H, default 2048, rows per frame (H >= 1).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port s_pix  input  pixel_t (8)  one input pixel.
REQ-006 SHALL have port s_valid  input  1  s_pix valid.
REQ-007 SHALL have port s_sof  input  1  s_pix is first pixel of a frame; qualified by s_valid.
REQ-008 SHALL have port s_ready  output  1  pixel accepted when s_valid & s_ready.
REQ-009 SHALL have port out_pix  output  pix_bus_t (8 x pixel_t)  packed beat; lane 0 = leftmost pixel.
REQ-010 SHALL have port out_valid  output  1  one-cycle beat strobe, no backpressure; feeds the 8-px line buffer in_valid.
REQ-011 SHALL have port out_eol  output  1  beat is last of a line.
REQ-012 SHALL have port out_eof  output  1  beat is last of a frame.
REQ-013 SHALL have port frame_err  output  1  sticky framing error flag.

Function
REQ-014 SHALL implement states WAIT_SOF and ACTIVE.
REQ-015 In WAIT_SOF, accepted pixels without s_sof SHALL be discarded; accepted pixel with s_sof SHALL enter ACTIVE and load lane 0, col=1, row=0.
REQ-016 In ACTIVE, each accepted pixel SHALL load lane (col mod 8) and increment col.
REQ-017 s_ready SHALL be 1 whenever rst_n is high; the block never stalls input.
REQ-018 A beat SHALL be emitted at the edge accepting lane 7, or the pixel at col W-1, whichever first.
REQ-019 Emission: out_pix, out_eol, out_eof registered at that edge; out_valid=1 for exactly the following cycle, 0 otherwise (latency 1 edge from last contributing pixel).
REQ-020 Partial last beat (W mod 8 != 0): unfilled lanes SHALL replicate pixel col W-1 (edge replication); W=3124 gives 391 beats/line, last beat lanes 4-7 = pixel 3123.
REQ-021 At col W-1: out_eol=1, col wraps to 0, row increments; if row was H-1, out_eof=1, row=0, state returns to WAIT_SOF.
REQ-022 s_sof accepted in ACTIVE at col!=0 or row!=0 SHALL set frame_err, discard partial beat (no emission), and restart at col=0,row=0 with this pixel in lane 0.
REQ-023 s_sof accepted exactly at col=0,row=0 in ACTIVE SHALL be legal, no error.
REQ-024 frame_err SHALL remain 1 until reset.
REQ-025 out_pix SHALL hold its last value when out_valid=0.
REQ-026 Counters col (ceil log2 W bits) and row (ceil log2 H bits) SHALL never exceed W-1 and H-1.

Reset
REQ-027 rst_n low SHALL asynchronously force: state WAIT_SOF, col=0, row=0, out_valid=0, out_eol=0, out_eof=0, frame_err=0, out_pix=0, s_ready=0.
REQ-028 Reset mid-beat SHALL discard partial lanes; no beat emitted after release until a new s_sof.
REQ-029 Reset release SHALL be synchronised so first acceptance occurs no earlier than the second rising edge after deassertion.

Verification (W=20, H=2)
REQ-030 Frame of pixels 0..39 with s_sof on pixel 0, s_valid continuous -> 6 beats; beat0 = 0..7, beat2 = 16,17,18,19,19,19,19,19 with out_eol=1; beat5 out_eol=1,out_eof=1; frame_err=0.
REQ-031 s_valid toggled 1/0 every cycle for same frame -> identical beat contents; out_valid pulses never 2 cycles wide.
REQ-032 10 pixels without s_sof then a frame -> first 10 discarded, beat0 = first frame pixel lanes 0..7.
REQ-033 s_sof reasserted at pixel 13 of a frame -> frame_err=1 sticky, no beat containing pixels 8..12, next beat lanes from restart pixel.
REQ-034 rst_n pulsed low after pixel 5 -> all outputs 0 immediately, no out_valid until next s_sof frame, which packs from lane 0.
REQ-035 Back-to-back frames (s_sof on pixel 40) -> no frame_err, 12 beats total, out_eof on beats 5 and 11.

Source files
------------

// File: rtl/gauss_pix_pack_8px.sv
// Pixel packer: gathers a stream of 8-bit pixels into 8-lane beats (lane 0 = leftmost).
// Beats close on lane 7 or on the last pixel of a line. A short last beat is padded
// by repeating the line's final pixel. An s_sof arriving mid-frame sets a sticky error
// and restarts the frame from that pixel.
module gauss_pix_pack_8px #(
   parameter int unsigned W = 3124,
   parameter int unsigned H = 2048
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  s_pix,
   input  logic        s_valid,
   input  logic        s_sof,
   output logic        s_ready,
   output logic [63:0] out_pix,
   output logic        out_valid,
   output logic        out_eol,
   output logic        out_eof,
   output logic        frame_err
);

   localparam int unsigned CW = $clog2(W);
   localparam int unsigned RW = (H > 1) ? $clog2(H) : 1;
   localparam logic [CW-1:0] ColLast = CW'(W - 1);
   localparam logic [RW-1:0] RowLast = RW'(H - 1);

   typedef enum logic {StWaitSof, StActive} state_t;

   state_t        r_state;
   logic [1:0]    r_sync;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [63:0]   r_buf;
   logic [63:0]   r_out_pix;
   logic          r_out_valid;
   logic          r_out_eol;
   logic          r_out_eof;
   logic          r_frame_err;

   logic          w_acc;
   logic [2:0]    w_lane;
   logic          w_last_col;
   logic          w_sof_err;
   logic          w_emit;
   logic [63:0]   w_beat;

   assign w_acc      = s_valid & r_sync[1];
   assign w_lane     = r_col[2:0];
   assign w_last_col = (r_col == ColLast);
   // s_sof anywhere but the very first position of a frame is a framing error
   assign w_sof_err  = (r_state == StActive) && s_sof && ((r_col != '0) || (r_row != '0));
   assign w_emit     = w_acc && (r_state == StActive) && !w_sof_err &&
                       ((w_lane == 3'd7) || w_last_col);

   // Merge the incoming pixel into the lane buffer; on the line's last pixel,
   // every lane to its right is filled with that same pixel.
   always_comb begin
      w_beat = r_buf;
      for (int l = 0; l < 8; l++) begin
         if ((l == int'(w_lane)) || (w_last_col && (l > int'(w_lane)))) begin
            w_beat[8*l +: 8] = s_pix;
         end
      end
   end

   // Reset-release synchroniser; s_ready rises two edges after rst_n deasserts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], 1'b1};
      end
   end

   // Framing FSM, position counters, lane buffer and registered beat outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StWaitSof;
         r_col       <= '0;
         r_row       <= '0;
         r_buf       <= '0;
         r_out_pix   <= '0;
         r_out_valid <= 1'b0;
         r_out_eol   <= 1'b0;
         r_out_eof   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_out_valid <= w_emit;
         r_out_eol   <= w_emit & w_last_col;
         r_out_eof   <= w_emit & w_last_col & (r_row == RowLast);
         if (w_emit) begin
            r_out_pix <= w_beat;
         end
         if (w_acc) begin
            unique case (r_state)
               StWaitSof: begin
                  if (s_sof) begin
                     r_state    <= StActive;
                     r_buf[7:0] <= s_pix;
                     r_col      <= CW'(1);
                     r_row      <= '0;
                  end
               end
               StActive: begin
                  if (w_sof_err) begin
                     // Partial beat is dropped; restart with this pixel in lane 0
                     r_frame_err <= 1'b1;
                     r_buf[7:0]  <= s_pix;
                     r_col       <= CW'(1);
                     r_row       <= '0;
                  end else begin
                     r_buf <= w_beat;
                     if (w_last_col) begin
                        r_col <= '0;
                        if (r_row == RowLast) begin
                           r_row   <= '0;
                           r_state <= StWaitSof;
                        end else begin
                           r_row <= r_row + RW'(1);
                        end
                     end else begin
                        r_col <= r_col + CW'(1);
                     end
                  end
               end
               default: r_state <= StWaitSof;
            endcase
         end
      end
   end

   assign s_ready   = r_sync[1];
   assign out_pix   = r_out_pix;
   assign out_valid = r_out_valid;
   assign out_eol   = r_out_eol;
   assign out_eof   = r_out_eof;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_gauss_pix_pack_8px.sv
// Randomised bench for gauss_pix_pack_8px (W=20, H=2) with a queue-based frame model.
module tb_gauss_pix_pack_8px;

   localparam int W = 20;
   localparam int H = 2;

   logic        clk;
   logic        rst_n;
   logic [7:0]  s_pix;
   logic        s_valid;
   logic        s_sof;
   logic        s_ready;
   logic [63:0] out_pix;
   logic        out_valid;
   logic        out_eol;
   logic        out_eof;
   logic        frame_err;

   gauss_pix_pack_8px #(.W(W), .H(H)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_pix     (s_pix),
      .s_valid   (s_valid),
      .s_sof     (s_sof),
      .s_ready   (s_ready),
      .out_pix   (out_pix),
      .out_valid (out_valid),
      .out_eol   (out_eol),
      .out_eof   (out_eof),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pix;
      logic        eol;
      logic        eof;
   } beat_t;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Reference model: the current line is a plain list of pixels
   beat_t       exp_q[$];
   logic [7:0]  m_line[$];
   bit          m_act;
   int          m_row;
   bit          m_err;
   logic [63:0] last_exp;
   int          n_beats;
   bit          prev_valid;

   task automatic model_reset();
      m_act = 0; m_row = 0; m_err = 0;
      m_line.delete();
      exp_q.delete();
      last_exp = '0;
   endtask

   task automatic model_accept(input logic [7:0] p, input logic sof);
      beat_t b;
      int    n, base, idx;
      if (!m_act) begin
         if (sof) begin
            m_act = 1; m_row = 0;
            m_line.delete();
            m_line.push_back(p);
         end
         return;
      end
      if (sof && (m_line.size() != 0 || m_row != 0)) begin
         m_err = 1; m_row = 0;
         m_line.delete();
         m_line.push_back(p);
         return;
      end
      m_line.push_back(p);
      n = m_line.size();
      if (n % 8 == 0 || n == W) begin
         base = ((n - 1) / 8) * 8;
         for (int l = 0; l < 8; l++) begin
            idx = base + l;
            b.pix[8*l +: 8] = (idx < n) ? m_line[idx] : m_line[n-1];
         end
         b.eol = (n == W);
         b.eof = b.eol && (m_row == H - 1);
         exp_q.push_back(b);
         if (b.eol) begin
            m_line.delete();
            m_row++;
            if (m_row == H) begin
               m_row = 0;
               m_act = 0;
            end
         end
      end
   endtask

   // Output monitor, sampled mid-cycle
   always @(negedge clk) begin
      beat_t e;
      if (rst_n) begin
         if (out_valid) begin
            n_beats++;
            chk("pulse_width", 64'(prev_valid), 64'(0));
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", out_pix, 64'hx);
            end else begin
               e = exp_q.pop_front();
               chk("beat_pix", out_pix, e.pix);
               chk("beat_eol", 64'(out_eol), 64'(e.eol));
               chk("beat_eof", 64'(out_eof), 64'(e.eof));
               last_exp = e.pix;
            end
         end else begin
            chk("pix_hold", out_pix, last_exp);
         end
         prev_valid = out_valid;
      end else begin
         prev_valid = 1'b0;
      end
   end

   // One cycle of stimulus; returns whether the pixel was accepted
   task automatic drive(input logic [7:0] p, input logic sof, input bit v, output bit acc);
      s_valid = v; s_pix = p; s_sof = sof;
      @(negedge clk);
      acc = v && s_ready;
      if (acc) model_accept(p, sof);
      @(posedge clk);
      #1;
      s_valid = 1'b0; s_sof = 1'b0;
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0, a);
   endtask

   task automatic send(input logic [7:0] p, input logic sof);
      bit a;
      a = 0;
      for (int t = 0; t < 20 && !a; t++) drive(p, sof, 1'b1, a);
      if (!a) chk("accept_timeout", 64'(0), 64'(1));
   endtask

   // gap: 0 = continuous, 1 = idle after each pixel, 2 = random 0..2 idles
   task automatic send_frame(input int base, input int gap);
      for (int i = 0; i < W * H; i++) begin
         send(8'(base + i), i == 0);
         if (gap == 1) idle(1);
         else if (gap == 2) idle($urandom_range(0, 2));
      end
   endtask

   task automatic drain(input string tag);
      idle(4);
      chk(tag, 64'(exp_q.size()), 64'(0));
      chk("frame_err", 64'(frame_err), 64'(m_err));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_ready", 64'(s_ready), 64'(0));
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_pix", out_pix, 64'(0));
      chk("rst_eol", 64'({out_eol, out_eof}), 64'(0));
      chk("rst_err", 64'(frame_err), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_sync", 64'(s_ready), 64'(0));
      for (int t = 0; t < 10 && !s_ready; t++) begin
         @(posedge clk);
         #1;
      end
      chk("ready_up", 64'(s_ready), 64'(1));
   endtask

   int b0;

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_pix = '0;
      n_beats = 0; prev_valid = 0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Continuous frame 0..39
      b0 = n_beats;
      send_frame(0, 0);
      drain("frame_drain");
      chk("frame_beats", 64'(n_beats - b0), 64'(6));

      // Same frame with s_valid toggling
      b0 = n_beats;
      send_frame(0, 1);
      drain("toggle_drain");
      chk("toggle_beats", 64'(n_beats - b0), 64'(6));

      // Ten stray pixels before the frame are discarded
      for (int i = 0; i < 10; i++) send(8'(200 + i), 1'b0);
      b0 = n_beats;
      send_frame(64, 0);
      drain("discard_drain");
      chk("discard_beats", 64'(n_beats - b0), 64'(6));

      // Back-to-back frames
      b0 = n_beats;
      send_frame(100, 0);
      send_frame(140, 0);
      drain("b2b_drain");
      chk("b2b_beats", 64'(n_beats - b0), 64'(12));

      // s_sof again at pixel 13 restarts the frame with a sticky error
      for (int i = 0; i < 13; i++) send(8'(i), i == 0);
      for (int i = 0; i < W * H; i++) send(8'(50 + i), i == 0);
      drain("err_drain");
      chk("err_set", 64'(frame_err), 64'(1));
      send_frame(7, 0);
      drain("err_sticky_drain");

      // Reset after pixel 5; only a fresh s_sof frame produces beats
      for (int i = 0; i < 6; i++) send(8'(90 + i), i == 0);
      do_reset();
      for (int i = 0; i < 12; i++) send(8'(30 + i), 1'b0);
      b0 = n_beats;
      send_frame(220, 0);
      drain("reset_drain");
      chk("reset_beats", 64'(n_beats - b0), 64'(6));

      // Random frames with gaps, junk pixels and the odd stray s_sof
      for (int f = 0; f < 6; f++) begin
         for (int j = $urandom_range(0, 4); j > 0; j--) send(8'($urandom), 1'b0);
         for (int i = 0; i < W * H; i++) begin
            send(8'($urandom), (i == 0) || ($urandom_range(0, 59) == 0));
            idle($urandom_range(0, 2));
         end
      end
      drain("rand_drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
